ccm_ctr_sched: RTL and testbench

CCM_CTR_SCHED -- requirements
Module: ccm_ctr_sched

---
 rtl/ccm_pkg.sv | 17 +
 rtl/ccm_rr_arb2.sv | 19 +
 rtl/ccm_ctr_sched.sv | 168 ++++++++++++++++
 tb/tb_ccm_ctr_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_pkg.sv
// Purpose : shared CCM scheduler definitions (state encoding, AES block size).
// Latency : n/a, types and constants only.
// Backpr. : n/a.
package ccm_pkg;

  // One AES block; the CTR datapath always emits a full block per drain.
  localparam int BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ccm_state_e;

endpackage

// File: rtl/ccm_rr_arb2.sv
// Purpose : two-way round-robin arbiter, pure combinational.
// Latency : 0 cycles, gnt follows req/last in the same cycle.
// Backpr. : none; the caller decides when a grant is taken.
// Ports   : req[1:0] requests, last = index granted last, gnt[1:0] one-hot grant.
module ccm_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ccm_ctr_sched.sv
// Purpose : arbitrates two packet requesters and sequences one packet at a time
//           into the CCM CTR datapath: clear, feed 16-byte blocks, drain each block.
// Latency : grant is combinational in IDLE; ctr_clr one cycle after the grant;
//           ctr_input_en is combinational from s_valid while feeding.
// Backpr. : s_ready is high only in FEED; s_valid low stalls with no timeout.
// Ports   : req/len/nonce/flag per requester, gnt pulses; s_data/s_valid/s_ready
//           payload stream; ctr_* to/from the CTR datapath; busy, done, done_id status.
module ccm_ctr_sched
  import ccm_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [WIDTH-1:0]       len0,
  input  logic [WIDTH-1:0]       len1,
  input  logic [WIDTH_NONCE-1:0] nonce0,
  input  logic [WIDTH_NONCE-1:0] nonce1,
  input  logic [WIDTH_FLAG-1:0]  flag0,
  input  logic [WIDTH_FLAG-1:0]  flag1,
  output logic                   gnt0,
  output logic                   gnt1,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   ctr_clr,
  output logic [WIDTH-1:0]       ctr_input_data,
  output logic                   ctr_input_en,
  output logic [WIDTH-1:0]       ctr_input_data_length,
  output logic [WIDTH_NONCE-1:0] ctr_nonce,
  output logic [WIDTH_FLAG-1:0]  ctr_flag,
  input  logic                   ctr_out_en,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id
);

  localparam logic [3:0] BLK_LAST = 4'(BLOCK_BYTES - 1);

  ccm_state_e             state_q, state_d;
  logic                   last_q, last_d;
  logic                   hold_q, hold_d;
  logic                   id_q, id_d;
  logic [WIDTH-1:0]       len_q, len_d;
  logic [WIDTH-1:0]       bytes_left_q, bytes_left_d;
  logic [WIDTH_NONCE-1:0] nonce_q, nonce_d;
  logic [WIDTH_FLAG-1:0]  flag_q, flag_d;
  logic [3:0]             blk_cnt_q, blk_cnt_d;
  logic [3:0]             drain_cnt_q, drain_cnt_d;
  logic [1:0]             arb_gnt;
  logic                   arb_en;

  ccm_rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // hold_q blanks arbitration for one IDLE cycle after DONE, and it resets
  // high so requests seen during or right at reset release never grant.
  assign arb_en = (state_q == ST_IDLE) && !hold_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      hold_q       <= 1'b1;
      id_q         <= 1'b0;
      len_q        <= '0;
      bytes_left_q <= '0;
      nonce_q      <= '0;
      flag_q       <= '0;
      blk_cnt_q    <= '0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      id_q         <= id_d;
      len_q        <= len_d;
      bytes_left_q <= bytes_left_d;
      nonce_q      <= nonce_d;
      flag_q       <= flag_d;
      blk_cnt_q    <= blk_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    hold_d       = 1'b0;
    id_d         = id_q;
    len_d        = len_q;
    bytes_left_d = bytes_left_q;
    nonce_d      = nonce_q;
    flag_d       = flag_q;
    blk_cnt_d    = blk_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && (arb_gnt != 2'b00)) begin
          id_d         = arb_gnt[1];
          len_d        = arb_gnt[1] ? len1 : len0;
          bytes_left_d = arb_gnt[1] ? len1 : len0;
          nonce_d      = arb_gnt[1] ? nonce1 : nonce0;
          flag_d       = arb_gnt[1] ? flag1 : flag0;
          blk_cnt_d    = '0;
          drain_cnt_d  = '0;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = (bytes_left_q == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        if (s_valid) begin
          bytes_left_d = bytes_left_q - WIDTH'(1);
          blk_cnt_d    = blk_cnt_q + 4'd1;
          // Block boundary or final byte: hand the block to the datapath.
          if ((blk_cnt_q == BLK_LAST) || (bytes_left_q == WIDTH'(1))) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // A short last block still yields a full padded block of output.
        if (ctr_out_en) begin
          drain_cnt_d = drain_cnt_q + 4'd1;
          if (drain_cnt_q == BLK_LAST) begin
            blk_cnt_d   = '0;
            drain_cnt_d = '0;
            state_d     = (bytes_left_q != '0) ? ST_FEED : ST_DONE;
          end
        end
      end
      ST_DONE: begin
        last_d  = id_q;
        hold_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gnt0                  = arb_en & arb_gnt[0];
    gnt1                  = arb_en & arb_gnt[1];
    busy                  = (state_q != ST_IDLE);
    ctr_clr               = (state_q == ST_CLEAR);
    s_ready               = (state_q == ST_FEED);
    ctr_input_en          = (state_q == ST_FEED) & s_valid;
    ctr_input_data        = (state_q == ST_FEED) ? s_data : '0;
    ctr_input_data_length = len_q;
    ctr_nonce             = nonce_q;
    ctr_flag              = flag_q;
    done                  = (state_q == ST_DONE);
    done_id               = (state_q == ST_DONE) & id_q;
  end

endmodule

// File: tb/tb_ccm_ctr_sched.sv
module tb_ccm_ctr_sched;
  localparam int W  = 8;
  localparam int WN = 100;
  localparam int WF = 8;
  localparam int K_CLR = 0, K_FEED = 1, K_DRAIN = 2, K_DONE = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  len0 = '0, len1 = '0;
  logic [WN-1:0] nonce0 = '0, nonce1 = '0;
  logic [WF-1:0] flag0 = '0, flag1 = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          ctr_out_en = 1'b0;
  logic          gnt0, gnt1, s_ready, ctr_clr, ctr_input_en, busy, done, done_id;
  logic [W-1:0]  ctr_input_data, ctr_input_data_length;
  logic [WN-1:0] ctr_nonce;
  logic [WF-1:0] ctr_flag;

  ccm_ctr_sched #(.WIDTH(W), .WIDTH_NONCE(WN), .WIDTH_FLAG(WF)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .nonce0(nonce0), .nonce1(nonce1), .flag0(flag0), .flag1(flag1),
    .gnt0(gnt0), .gnt1(gnt1),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ctr_clr(ctr_clr), .ctr_input_data(ctr_input_data), .ctr_input_en(ctr_input_en),
    .ctr_input_data_length(ctr_input_data_length), .ctr_nonce(ctr_nonce), .ctr_flag(ctr_flag),
    .ctr_out_en(ctr_out_en), .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: on each grant the whole packet is planned as a list of
  // phases (clear, feed k bytes, drain 16 strobes, ..., done) from the length.
  int            pk[$];
  int            pn[$];
  int            m_lg = 1;
  int            m_cool = 1;
  int            m_id = 0;
  logic [W-1:0]  m_len = '0;
  logic [WN-1:0] m_nonce = '0;
  logic [WF-1:0] m_flag = '0;

  // Independent monitor counters used by the directed literal checks.
  int cyc = 0, n_en = 0, n_clr = 0, n_drain = 0, n_ready = 0, n_done = 0, bad_order = 0;
  int t_gnt = 0, t_done = 0;
  int gq[$];
  int dq[$];
  bit clr_seen = 1'b0;

  logic [6:0] mctl, ectl;
  int         mw, rem, kk;

  always @(negedge clk) begin
    cyc++;
    mctl = {gnt0, gnt1, busy, s_ready, ctr_clr, ctr_input_en, done};
    if (!reset) begin
      chk("reset_ctl", mctl, 0);
      chk("reset_bus", {done_id, ctr_input_data, ctr_input_data_length, ctr_flag}, 0);
      chk("reset_nonce", ctr_nonce, 0);
      pk.delete();
      pn.delete();
      m_lg = 1;
      m_cool = 1;
      clr_seen = 1'b0;
    end else begin
      n_en    += int'(ctr_input_en);
      n_clr   += int'(ctr_clr);
      n_ready += int'(s_ready);
      if (busy && !s_ready && !ctr_clr && !done && ctr_out_en) n_drain++;
      if (gnt0 || gnt1) begin gq.push_back(int'(gnt1)); t_gnt = cyc; clr_seen = 1'b0; end
      if (ctr_clr) clr_seen = 1'b1;
      if (ctr_input_en && !clr_seen) bad_order++;
      if (done) begin dq.push_back(int'(done_id)); t_done = cyc; n_done++; end

      if (pk.size() == 0) begin
        mw = -1;
        if (m_cool != 0) m_cool = 0;
        else if (req0 && req1) mw = 1 - m_lg;
        else if (req0) mw = 0;
        else if (req1) mw = 1;
        ectl = {mw == 0, mw == 1, 5'b00000};
        chk("idle_ctl", mctl, ectl);
        if (mw >= 0) begin
          m_id    = mw;
          m_len   = (mw == 1) ? len1 : len0;
          m_nonce = (mw == 1) ? nonce1 : nonce0;
          m_flag  = (mw == 1) ? flag1 : flag0;
          pk.push_back(K_CLR); pn.push_back(1);
          rem = int'(m_len);
          while (rem > 0) begin
            kk = (rem > 16) ? 16 : rem;
            pk.push_back(K_FEED);  pn.push_back(kk);
            pk.push_back(K_DRAIN); pn.push_back(16);
            rem -= kk;
          end
          pk.push_back(K_DONE); pn.push_back(1);
        end
      end else begin
        chk("len_latch", ctr_input_data_length, m_len);
        chk("nonce_latch", ctr_nonce, m_nonce);
        chk("flag_latch", ctr_flag, m_flag);
        case (pk[0])
          K_CLR: begin
            chk("clear_ctl", mctl, 7'b0010100);
            void'(pk.pop_front()); void'(pn.pop_front());
          end
          K_FEED: begin
            chk("feed_ctl", mctl, {4'b0011, 1'b0, s_valid, 1'b0});
            if (s_valid) begin
              chk("feed_data", ctr_input_data, s_data);
              pn[0] = pn[0] - 1;
              if (pn[0] == 0) begin void'(pk.pop_front()); void'(pn.pop_front()); end
            end
          end
          K_DRAIN: begin
            chk("drain_ctl", mctl, 7'b0010000);
            if (ctr_out_en) begin
              pn[0] = pn[0] - 1;
              if (pn[0] == 0) begin void'(pk.pop_front()); void'(pn.pop_front()); end
            end
          end
          default: begin
            chk("done_ctl", mctl, 7'b0010001);
            chk("done_id", done_id, m_id);
            m_lg = m_id;
            m_cool = 1;
            void'(pk.pop_front()); void'(pn.pop_front());
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 valid held, 1 toggling, 2 random. omode: 0 out_en held, 1 random.
  task automatic drive_cycle(input int vmode, input int omode);
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()}; nonce0 = r[WN-1:0];
    r = {$urandom(), $urandom(), $urandom(), $urandom()}; nonce1 = r[WN-1:0];
    flag0  = WF'($urandom());
    flag1  = WF'($urandom());
    s_data = W'($urandom());
    case (vmode)
      0:       s_valid = 1'b1;
      1:       s_valid = !s_valid;
      default: s_valid = ($urandom_range(0, 3) != 0);
    endcase
    ctr_out_en = (omode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
  endtask

  int sn_en, sn_clr, sn_drain, sn_ready, sn_g, sn_d, sn_done, sn_bad;
  task automatic snap();
    sn_en = n_en; sn_clr = n_clr; sn_drain = n_drain; sn_ready = n_ready;
    sn_g = gq.size(); sn_d = dq.size(); sn_done = n_done; sn_bad = bad_order;
  endtask

  task automatic run_pkts(input bit r0, input bit r1, input int l0, input int l1,
                          input int vmode, input int omode, input int ndone, input bit drop);
    int d0, g0, budget;
    d0 = n_done; g0 = gq.size(); budget = 0;
    req0 = r0; req1 = r1; len0 = W'(l0); len1 = W'(l1);
    while ((n_done - d0 < ndone) && (budget < 2000)) begin
      drive_cycle(vmode, omode);
      if (drop && (gq.size() > g0)) begin req0 = 1'b0; req1 = 1'b0; end
      budget++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("pkt_timeout", budget < 2000, 1'b1);
    tick(); tick();
  endtask

  initial begin
    int budget;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // 16-byte packet from requester 0, everything streaming.
    snap();
    run_pkts(1, 0, 16, 0, 0, 0, 1, 1);
    chk("s1_en", n_en - sn_en, 16);
    chk("s1_clr", n_clr - sn_clr, 1);
    chk("s1_drain", n_drain - sn_drain, 16);
    chk("s1_gnt", (sn_g < gq.size()) ? gq[sn_g] : -1, 0);
    chk("s1_done_id", (sn_d < dq.size()) ? dq[sn_d] : -1, 0);
    chk("s1_latency", t_done - t_gnt, 34);

    // 20-byte packet from requester 1: two blocks, the second one partial.
    snap();
    run_pkts(0, 1, 0, 20, 0, 0, 1, 1);
    chk("s2_en", n_en - sn_en, 20);
    chk("s2_drain", n_drain - sn_drain, 32);
    chk("s2_done_id", (sn_d < dq.size()) ? dq[sn_d] : -1, 1);
    chk("s2_latency", t_done - t_gnt, 54);

    // Both requesting continuously: alternation.
    snap();
    run_pkts(1, 1, 8, 8, 0, 0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      chk("s3_gnt_order", (sn_g + i < gq.size()) ? gq[sn_g + i] : -1, i % 2);
      chk("s3_done_order", (sn_d + i < dq.size()) ? dq[sn_d + i] : -1, i % 2);
    end
    chk("s3_en", n_en - sn_en, 32);
    chk("s3_ngnt", gq.size() - sn_g, 4);

    // Zero-length packet.
    snap();
    run_pkts(1, 0, 0, 0, 0, 0, 1, 1);
    chk("s4_en", n_en - sn_en, 0);
    chk("s4_ready", n_ready - sn_ready, 0);
    chk("s4_clr", n_clr - sn_clr, 1);
    chk("s4_latency", t_done - t_gnt, 2);

    // s_valid toggling every other cycle.
    snap();
    run_pkts(1, 0, 16, 0, 1, 0, 1, 1);
    chk("s5_en", n_en - sn_en, 16);
    chk("s5_drain", n_drain - sn_drain, 16);

    // Reset after byte 5, requester still asserting during reset.
    snap();
    req0 = 1'b1; len0 = 8'd16; budget = 0;
    while ((n_en - sn_en < 5) && (budget < 200)) begin
      drive_cycle(0, 0);
      if (gq.size() > sn_g) req0 = 1'b0;
      budget++;
    end
    chk("s6_reach5", n_en - sn_en, 5);
    reset = 1'b0; req0 = 1'b1;
    repeat (3) drive_cycle(0, 0);
    chk("s6_no_done", n_done - sn_done, 0);
    reset = 1'b1;
    snap();
    run_pkts(1, 0, 16, 0, 0, 0, 1, 1);
    chk("s6_en", n_en - sn_en, 16);
    chk("s6_clr_first", bad_order - sn_bad, 0);
    chk("s6_clr", n_clr - sn_clr, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req0 = 1'($urandom_range(0, 1));
        req1 = 1'($urandom_range(0, 1));
      end
      if (!req0 || ($urandom_range(0, 7) == 0)) len0 = W'($urandom_range(0, 40));
      if (!req1 || ($urandom_range(0, 7) == 0)) len1 = W'($urandom_range(0, 40));
      drive_cycle(2, 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    budget = 0;
    while ((busy || (pk.size() != 0)) && (budget < 1000)) begin
      drive_cycle(2, 1);
      budget++;
    end
    chk("final_idle", {busy, pk.size() != 0}, 2'b00);
    chk("rand_order", bad_order, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
